// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C init sequencer: table opcodes, FSM states and
// opcode field position helpers for a table word of PAYLOAD_W+2 bits.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_END   = 2'b10,
    OP_NOP   = 2'b11
  } seq_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_REISSUE,
    S_WAIT_DLY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam int OP_W = 2;

  function automatic int op_lsb(input int payload_w);
    return payload_w;
  endfunction

  function automatic int op_msb(input int payload_w);
    return payload_w + OP_W - 1;
  endfunction

endpackage

// File: rtl/i2c_init_seq.sv
// Walks an opcode-tagged config table, issuing WRITEs to an external I2C controller
// with bounded NACK retry; 3 clk per entry plus strobe waits, stalls on ctl_reg_done.
module i2c_init_seq
  import i2c_seq_pkg::*;
#(
  parameter int NUM_ENTRIES = 65,
  parameter int PAYLOAD_W   = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES + 1),
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_START  = 1
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   strobe_100kHz,
  input  logic                   start,
  output logic [IDX_W-1:0]       tbl_addr,
  output logic                   tbl_rd,
  input  logic [PAYLOAD_W+1:0]   tbl_data,
  output logic                   ctl_enable,
  output logic [PAYLOAD_W-1:0]   ctl_reg_addr,
  input  logic                   ctl_reg_done,
  input  logic                   ctl_nack,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [IDX_W-1:0]       err_index,
  output logic [IDX_W-1:0]       entry_idx
);

  localparam int OP_LSB = op_lsb(PAYLOAD_W);
  localparam int OP_MSB = op_msb(PAYLOAD_W);
  localparam int RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_ENTRIES);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
  localparam logic             AUTO_GO = (AUTO_START != 0);

  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      entry_q, entry_d;
  logic [IDX_W-1:0]      err_idx_q, err_idx_d;
  logic [RTY_W-1:0]      retry_q, retry_d;
  logic [PAYLOAD_W-1:0]  dly_q, dly_d;
  logic [PAYLOAD_W-1:0]  wr_dat_q, wr_dat_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  auto_q, auto_d;

  seq_op_t               op;
  logic [PAYLOAD_W-1:0]  payload;
  logic [IDX_W-1:0]      entry_inc;

  assign op        = seq_op_t'(tbl_data[OP_MSB:OP_LSB]);
  assign payload   = tbl_data[PAYLOAD_W-1:0];
  assign entry_inc = entry_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    err_idx_d = err_idx_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    wr_dat_d  = wr_dat_q;
    done_d    = done_q;
    error_d   = error_q;
    auto_d    = auto_q;

    case (state_q)
      S_IDLE: begin
        // auto_q is a one-shot armed by reset so AUTO_START runs exactly once per reset
        if (start || auto_q) begin
          state_d = S_FETCH;
          auto_d  = 1'b0;
          entry_d = '0;
          retry_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_WRITE: begin
            wr_dat_d = payload;
            state_d  = S_ISSUE;
          end
          OP_DELAY: begin
            dly_d   = payload;
            state_d = S_WAIT_DLY;
          end
          OP_END: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          default: state_d = S_NEXT;
        endcase
      end
      S_ISSUE: begin
        if (strobe_100kHz && ctl_reg_done) begin
          if (!ctl_nack) begin
            state_d = S_NEXT;
          end else if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_REISSUE;
          end else begin
            error_d   = 1'b1;
            err_idx_d = entry_q;
            state_d   = S_ERROR;
          end
        end
      end
      // one clk with enable low so the controller sees a fresh transaction
      S_REISSUE: state_d = S_ISSUE;
      S_WAIT_DLY: begin
        if (dly_q == '0) begin
          state_d = S_NEXT;
        end else if (strobe_100kHz) begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        entry_d = entry_inc;
        if (entry_inc == END_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      entry_q   <= '0;
      err_idx_q <= '0;
      retry_q   <= '0;
      dly_q     <= '0;
      wr_dat_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      auto_q    <= AUTO_GO;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      err_idx_q <= err_idx_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      wr_dat_q  <= wr_dat_d;
      done_q    <= done_d;
      error_q   <= error_d;
      auto_q    <= auto_d;
    end
  end

  // Outputs decode straight from state_q so reset drops ctl_enable without a clock
  assign busy         = (state_q != S_IDLE);
  assign tbl_rd       = (state_q == S_FETCH);
  assign tbl_addr     = tbl_rd ? entry_q : '0;
  assign ctl_enable   = (state_q == S_ISSUE);
  assign ctl_reg_addr = wr_dat_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_index    = err_idx_q;
  assign entry_idx    = entry_q;

endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: table ROM and I2C controller models, write-payload scoreboard.
module tb_i2c_init_seq;
  import i2c_seq_pkg::*;

  localparam int PW  = 16;
  localparam int NA  = 8;
  localparam int IWA = $clog2(NA + 1);
  localparam int NB  = 4;
  localparam int IWB = $clog2(NB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset = 1'b0;
  logic strobe = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [IWA-1:0] tbl_addr_a, err_index_a, entry_idx_a;
  logic           tbl_rd_a, ctl_enable_a, busy_a, done_a, error_a;
  logic [PW+1:0]  tbl_data_a;
  logic [PW-1:0]  ctl_reg_addr_a;
  logic           ctl_reg_done_a = 1'b0;
  logic           ctl_nack_a = 1'b0;

  logic [IWB-1:0] tbl_addr_b, err_index_b, entry_idx_b;
  logic           tbl_rd_b, ctl_enable_b, busy_b, done_b, error_b;
  logic [PW+1:0]  tbl_data_b;
  logic [PW-1:0]  ctl_reg_addr_b;
  logic           ctl_reg_done_b, ctl_nack_b;

  i2c_init_seq #(.NUM_ENTRIES(NA), .PAYLOAD_W(PW), .MAX_RETRY(3), .AUTO_START(1)) u_dut_a (
    .clk(clk), .areset(areset), .strobe_100kHz(strobe), .start(start_a),
    .tbl_addr(tbl_addr_a), .tbl_rd(tbl_rd_a), .tbl_data(tbl_data_a),
    .ctl_enable(ctl_enable_a), .ctl_reg_addr(ctl_reg_addr_a),
    .ctl_reg_done(ctl_reg_done_a), .ctl_nack(ctl_nack_a),
    .busy(busy_a), .done(done_a), .error(error_a),
    .err_index(err_index_a), .entry_idx(entry_idx_a)
  );

  i2c_init_seq #(.NUM_ENTRIES(NB), .PAYLOAD_W(PW), .MAX_RETRY(3), .AUTO_START(0)) u_dut_b (
    .clk(clk), .areset(areset), .strobe_100kHz(strobe), .start(start_b),
    .tbl_addr(tbl_addr_b), .tbl_rd(tbl_rd_b), .tbl_data(tbl_data_b),
    .ctl_enable(ctl_enable_b), .ctl_reg_addr(ctl_reg_addr_b),
    .ctl_reg_done(ctl_reg_done_b), .ctl_nack(ctl_nack_b),
    .busy(busy_b), .done(done_b), .error(error_b),
    .err_index(err_index_b), .entry_idx(entry_idx_b)
  );

  logic [PW+1:0] mem_a [16];
  logic [PW+1:0] mem_b [8];
  always @(posedge clk) if (tbl_rd_a) tbl_data_a <= mem_a[tbl_addr_a];
  always @(posedge clk) if (tbl_rd_b) tbl_data_b <= mem_b[tbl_addr_b];

  // Controller B acks on the first strobe of every transaction
  assign ctl_reg_done_b = ctl_enable_b & strobe;
  assign ctl_nack_b     = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW+1:0] ent(input logic [1:0] op, input logic [PW-1:0] pl);
    return {op, pl};
  endfunction

  logic [PW-1:0] exp_q[$];
  int            rise_strobes[$];
  int            rise_a = 0, rise_b = 0, max_rd_a = -1, max_rd_b = -1;
  int            strobes_since = 0, tcnt_a = 0, div = 0, cyc = 0;
  int            last_rd_cyc = 0, last_fall_cyc = 0, nack_left = 0;
  logic [PW-1:0] nack_pay = '0;
  bit            rd_pend_a = 1'b0, en_prev_a = 1'b0, en_prev_b = 1'b0;

  // Table monitor, scoreboard, strobe generator and controller A model
  always @(negedge clk) begin : env
    logic s_prev;
    s_prev = strobe;
    cyc++;
    if (tbl_rd_a) begin
      if (int'(tbl_addr_a) > max_rd_a) max_rd_a = int'(tbl_addr_a);
      rd_pend_a   = 1'b1;
      last_rd_cyc = cyc;
    end
    if (s_prev && en_prev_a && ctl_reg_done_a && !ctl_nack_a) strobes_since = 0;
    else if (s_prev) strobes_since++;
    if (!ctl_enable_a && en_prev_a) last_fall_cyc = cyc;
    if (ctl_enable_a && !en_prev_a) begin
      rise_a++;
      rise_strobes.push_back(strobes_since);
      if (exp_q.size() == 0) check("sb_unexpected_write", {16'h0, ctl_reg_addr_a}, 32'hDEAD_BEEF);
      else check("sb_write_payload", {16'h0, ctl_reg_addr_a}, {16'h0, exp_q.pop_front()});
      if (rd_pend_a) check("fetch_to_enable_clks", cyc - last_rd_cyc, 2);
      else check("retry_enable_gap_clks", cyc - last_fall_cyc, 1);
      rd_pend_a = 1'b0;
    end
    if (!ctl_enable_a) tcnt_a = 0;
    else if (s_prev && en_prev_a) tcnt_a++;
    en_prev_a = ctl_enable_a;
    if (tbl_rd_b && int'(tbl_addr_b) > max_rd_b) max_rd_b = int'(tbl_addr_b);
    if (ctl_enable_b && !en_prev_b) rise_b++;
    en_prev_b = ctl_enable_b;
    div    = (div == 9) ? 0 : div + 1;
    strobe = (div == 9);
    ctl_reg_done_a = ctl_enable_a && strobe && (tcnt_a >= 1);
    ctl_nack_a     = ctl_reg_done_a && (nack_left > 0) && (ctl_reg_addr_a == nack_pay);
    if (ctl_nack_a) nack_left--;
  end

  task automatic wait_end_a(input int budget);
    int i = 0;
    while (!(done_a === 1'b1 || error_a === 1'b1) && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic start_pulse_a();
    @(negedge clk); #1 start_a = 1'b1;
    @(negedge clk); #1 start_a = 1'b0;
  endtask

  task automatic hold_reset();
    @(negedge clk); #1 areset = 1'b1;
    exp_q.delete();
    rise_strobes.delete();
    max_rd_a = -1;
    for (int i = 0; i < 16; i++) mem_a[i] = ent(OP_END, 16'h0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1 areset = 1'b0;
  endtask

  initial begin : stim
    int base;
    int i;
    #1 areset = 1'b1;
    #2;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_err_index", err_index_a, 0);
    check("rst_entry_idx", entry_idx_a, 0);
    check("rst_tbl_addr", tbl_addr_a, 0);
    check("rst_tbl_rd", tbl_rd_a, 0);
    check("rst_ctl_enable", ctl_enable_a, 0);
    check("rst_ctl_reg_addr", ctl_reg_addr_a, 0);
    for (int k = 0; k < 16; k++) mem_a[k] = ent(OP_END, 16'h0);
    for (int k = 0; k < 8; k++) mem_b[k] = ent(OP_END, 16'h0);

    // Three WRITEs then END, auto start after reset release
    mem_a[0] = ent(OP_WRITE, 16'h3008);
    mem_a[1] = ent(OP_WRITE, 16'h0103);
    mem_a[2] = ent(OP_WRITE, 16'h0100);
    mem_a[3] = ent(OP_END, 16'h0);
    exp_q.push_back(16'h3008); exp_q.push_back(16'h0103); exp_q.push_back(16'h0100);
    base = rise_a;
    release_reset();
    wait_end_a(2000);
    check("s1_busy_when_done_rises", busy_a, 1);
    @(negedge clk);
    check("s1_busy_falls_next", busy_a, 0);
    check("s1_done", done_a, 1);
    check("s1_error", error_a, 0);
    check("s1_entry_idx", entry_idx_a, 3);
    check("s1_writes", rise_a - base, 3);
    check("s1_sb_empty", exp_q.size(), 0);
    repeat (30) @(negedge clk);
    check("s1_no_rerun_when_idle", rise_a - base, 3);

    // DELAY 5 and DELAY 0 between WRITEs
    hold_reset();
    mem_a[0] = ent(OP_WRITE, 16'h1111);
    mem_a[1] = ent(OP_DELAY, 16'd5);
    mem_a[2] = ent(OP_WRITE, 16'h2222);
    mem_a[3] = ent(OP_DELAY, 16'd0);
    mem_a[4] = ent(OP_WRITE, 16'h3333);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    release_reset();
    wait_end_a(2000);
    check("s2_done", done_a, 1);
    check("s2_rises", rise_strobes.size(), 3);
    check("s2_delay5_strobes", rise_strobes[1], 5);
    check("s2_delay0_strobes", rise_strobes[2], 0);
    check("s2_entry_idx", entry_idx_a, 5);

    // Entry 2 NACKs twice then acks
    hold_reset();
    mem_a[0] = ent(OP_WRITE, 16'h0A00);
    mem_a[1] = ent(OP_WRITE, 16'h0A01);
    mem_a[2] = ent(OP_WRITE, 16'h0A02);
    mem_a[3] = ent(OP_WRITE, 16'h0A03);
    mem_a[4] = ent(OP_NOP, 16'hFFFF);
    nack_pay = 16'h0A02;
    nack_left = 2;
    exp_q.push_back(16'h0A00); exp_q.push_back(16'h0A01);
    for (int k = 0; k < 3; k++) exp_q.push_back(16'h0A02);
    exp_q.push_back(16'h0A03);
    base = rise_a;
    release_reset();
    wait_end_a(3000);
    check("s3_done", done_a, 1);
    check("s3_error", error_a, 0);
    check("s3_writes", rise_a - base, 6);
    check("s3_entry_idx", entry_idx_a, 5);
    check("s3_sb_empty", exp_q.size(), 0);

    // Entry 4 NACKs four times: abort, later entries never read
    hold_reset();
    mem_a[0] = ent(OP_WRITE, 16'h0B00);
    mem_a[1] = ent(OP_WRITE, 16'h0B01);
    mem_a[2] = ent(OP_WRITE, 16'h0B02);
    mem_a[3] = ent(OP_NOP, 16'h0000);
    mem_a[4] = ent(OP_WRITE, 16'h0B04);
    mem_a[5] = ent(OP_WRITE, 16'h0B05);
    mem_a[6] = ent(OP_WRITE, 16'h0B06);
    nack_pay = 16'h0B04;
    nack_left = 4;
    exp_q.push_back(16'h0B00); exp_q.push_back(16'h0B01); exp_q.push_back(16'h0B02);
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h0B04);
    base = rise_a;
    release_reset();
    wait_end_a(3000);
    check("s4_busy_when_error_rises", busy_a, 1);
    @(negedge clk);
    check("s4_busy_falls_next", busy_a, 0);
    check("s4_error", error_a, 1);
    check("s4_done", done_a, 0);
    check("s4_err_index", err_index_a, 4);
    check("s4_max_read_addr", max_rd_a, 4);
    check("s4_writes", rise_a - base, 7);

    // start after ERROR reruns from entry 0
    exp_q.push_back(16'h0B00); exp_q.push_back(16'h0B01); exp_q.push_back(16'h0B02);
    exp_q.push_back(16'h0B04); exp_q.push_back(16'h0B05); exp_q.push_back(16'h0B06);
    start_pulse_a();
    check("s4_error_cleared_on_rerun", error_a, 0);
    wait_end_a(3000);
    check("s4_rerun_done", done_a, 1);
    check("s4_rerun_error", error_a, 0);
    check("s4_rerun_entry_idx", entry_idx_a, 7);
    check("s4_rerun_writes", rise_a - base, 13);
    check("s4_rerun_sb_empty", exp_q.size(), 0);

    // Reset while ctl_enable is high
    hold_reset();
    #1 areset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = ent(OP_WRITE, 16'h0C00 + 16'(k));
      exp_q.push_back(16'h0C00 + 16'(k));
    end
    base = rise_a;
    i = 0;
    while (!((rise_a - base) >= 2 && ctl_enable_a === 1'b1) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("s5_enable_before_reset", ctl_enable_a, 1);
    #2 areset = 1'b1;
    #1;
    check("s5_async_ctl_enable", ctl_enable_a, 0);
    check("s5_async_busy", busy_a, 0);
    check("s5_async_entry_idx", entry_idx_a, 0);
    check("s5_async_ctl_reg_addr", ctl_reg_addr_a, 0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h0C00 + 16'(k));
    base = rise_a;
    release_reset();
    wait_end_a(3000);
    check("s5_done", done_a, 1);
    check("s5_writes", rise_a - base, 4);
    check("s5_entry_idx", entry_idx_a, 4);
    check("s5_sb_empty", exp_q.size(), 0);

    // NUM_ENTRIES=4 with no END; start while busy is ignored; start reruns
    for (int k = 0; k < 4; k++) mem_b[k] = ent(OP_WRITE, 16'h0D00 + 16'(k));
    repeat (20) @(negedge clk);
    check("s6_idle_without_start", busy_b, 0);
    @(negedge clk); #1 start_b = 1'b1;
    @(negedge clk); #1 start_b = 1'b0;
    i = 0;
    while (rise_b < 2 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    #1 start_b = 1'b1;
    check("s6_busy_at_start", busy_b, 1);
    @(negedge clk); #1 start_b = 1'b0;
    i = 0;
    while (busy_b !== 1'b0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("s6_done", done_b, 1);
    check("s6_error", error_b, 0);
    check("s6_entry_idx", entry_idx_b, 4);
    check("s6_max_read_addr", max_rd_b, 3);
    check("s6_writes", rise_b, 4);
    @(negedge clk); #1 start_b = 1'b1;
    @(negedge clk); #1 start_b = 1'b0;
    check("s6_rerun_busy", busy_b, 1);
    i = 0;
    while (busy_b !== 1'b0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("s6_rerun_done", done_b, 1);
    check("s6_rerun_writes", rise_b, 8);
    check("s6_rerun_max_read_addr", max_rd_b, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
